// File: rtl/alu_accumulator.sv
// Accumulator datapath: single-cycle add/sub/logic/load/rotate/clear ops plus a
// multi-cycle unsigned shift-add multiply, with busy/done status and sticky overflow.
module alu_accumulator #(
   parameter int unsigned W = 4
) (
   input  logic           CLK,
   input  logic           reset,
   input  logic           start,
   input  logic [2:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] acc,
   output logic           busy,
   output logic           done,
   output logic           ovf
);

   localparam int unsigned CW = $clog2(W + 1);

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e         state_q;
   logic [2*W-1:0] acc_q;
   logic [2*W-1:0] prod_q;
   logic [2*W-1:0] mcand_q;
   logic [W-1:0]   mult_q;
   logic [CW-1:0]  cnt_q;
   logic           busy_q;
   logic           done_q;
   logic           ovf_q;

   logic [2*W-1:0] ext_a;
   logic [2*W:0]   sum;
   logic [2*W-1:0] diff;
   logic           borrow;
   logic [2*W-1:0] prod_next;

   always_comb begin
      ext_a     = {{W{1'b0}}, a};
      sum       = {1'b0, acc_q} + {1'b0, ext_a};
      diff      = acc_q - ext_a;
      borrow    = (acc_q < ext_a);
      prod_next = prod_q + (mult_q[0] ? mcand_q : '0);
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q <= StIdle;
         acc_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
         mult_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (op == 3'b100) begin
                     // Operands are captured here; later changes on a/b are ignored.
                     mcand_q <= ext_a;
                     mult_q  <= b;
                     prod_q  <= '0;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= StMul;
                  end else begin
                     done_q <= 1'b1;
                     case (op)
                        3'b000: begin
                           acc_q <= '0;
                           ovf_q <= 1'b0;
                        end
                        3'b010: begin
                           acc_q <= sum[2*W-1:0];
                           ovf_q <= ovf_q | sum[2*W];
                        end
                        3'b011: begin
                           acc_q <= diff;
                           ovf_q <= ovf_q | borrow;
                        end
                        3'b101: acc_q <= {~(a & b), ~(a ^ b)};
                        3'b110: acc_q <= {a, b};
                        3'b111: acc_q <= {acc_q[2*W-2:0], acc_q[2*W-1]};
                        default: ;
                     endcase
                  end
               end
            end
            StMul: begin
               prod_q  <= prod_next;
               mcand_q <= mcand_q << 1;
               mult_q  <= mult_q >> 1;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == CW'(W - 1)) begin
                  acc_q   <= prod_next;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign acc  = acc_q;
   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = ovf_q;

endmodule
